// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the write-back result, drives the scalar and vector
// register-file write ports, and drains 144-bit vector results as 48-bit beats.
// Optional registered forwarding port is enabled with the WB_FORWARD_EN macro.
module writeback_stage #(
  parameter int DATA_W   = 144,
  parameter int BEAT_W   = 48,
  parameter int SCALAR_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2*DATA_W+13:0]  bufferIn,
  output logic                  stall,
  output logic                  sWe,
  output logic [3:0]            sRd,
  output logic [SCALAR_W-1:0]   sData,
  output logic                  vWe,
  output logic [3:0]            vRd,
  output logic [1:0]            vBeat,
  output logic [BEAT_W-1:0]     vData,
  output logic                  modeSelOut,
  output logic                  fwdValid,
  output logic [3:0]            fwdRd,
  output logic [DATA_W-1:0]     fwdData,
  output logic                  state_dbg
);

  localparam int NBEATS = DATA_W / BEAT_W;
  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);

  // Bundle field positions, laid out above the two DATA_W-wide result fields.
  localparam int RC_LSB   = 2 * DATA_W;
  localparam int RW_BIT   = RC_LSB + 4;
  localparam int M2R_BIT  = RC_LSB + 5;
  localparam int OPC_LSB  = RC_LSB + 6;
  localparam int MODE_BIT = RC_LSB + 12;
  localparam int RWV_BIT  = RC_LSB + 13;

  typedef enum logic {
    IDLE = 1'b0,
    VEC  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           beat;
  logic [1:0]           beat_next;

  logic [DATA_W-1:0]    alu_in;
  logic [DATA_W-1:0]    mem_in;
  logic [3:0]           rc_in;
  logic                 rw_in;
  logic                 m2r_in;
  logic                 mode_in;
  logic                 rwv_in;
  logic                 unused_fields;

  logic                 capture;
  logic [DATA_W-1:0]    result_q;
  logic [3:0]           rc_q;
  logic                 mode_q;
  logic                 s_pend;

  assign alu_in  = bufferIn[DATA_W-1:0];
  assign mem_in  = bufferIn[2*DATA_W-1:DATA_W];
  assign rc_in   = bufferIn[RC_LSB+3:RC_LSB];
  assign rw_in   = bufferIn[RW_BIT];
  assign m2r_in  = bufferIn[M2R_BIT];
  assign mode_in = bufferIn[MODE_BIT];
  assign rwv_in  = bufferIn[RWV_BIT];
  // opCode/opType travel with the bundle but are not decoded here.
  assign unused_fields = ^bufferIn[OPC_LSB+5:OPC_LSB];

  // Handshake: upstream presents bufferIn; it is taken at any rising edge with
  // en=1 and stall=0, and upstream must hold it unchanged while stall is high.
  assign capture = en && !stall;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next-state logic: a vector drains one beat per enabled edge; the edge that
  // retires the last beat may also take the next bundle with no bubble.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (capture && rwv_in) begin
          state_next = VEC;
          beat_next  = 2'd0;
        end
      end
      VEC: begin
        if (en) begin
          if (beat == LAST_BEAT) begin
            beat_next  = 2'd0;
            state_next = (capture && rwv_in) ? VEC : IDLE;
          end else begin
            beat_next = beat + 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = 2'd0;
      end
    endcase
  end

  // Output logic: strobes are registered intent qualified by en.
  always_comb begin
    stall     = (state == VEC) && (beat != LAST_BEAT);
    vWe       = (state == VEC) && en;
    sWe       = s_pend && en;
    vBeat     = beat;
    state_dbg = state;
    vData     = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat == 2'(k)) vData = result_q[k*BEAT_W +: BEAT_W];
    end
  end

  // Captured bundle; s_pend is cleared by the enabled edge that performs the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      rc_q     <= '0;
      mode_q   <= 1'b0;
      s_pend   <= 1'b0;
    end else if (capture) begin
      result_q <= m2r_in ? mem_in : alu_in;
      rc_q     <= rc_in;
      mode_q   <= mode_in;
      s_pend   <= rw_in;
    end else if (en) begin
      s_pend <= 1'b0;
    end
  end

  assign sRd        = rc_q;
  assign sData      = result_q[SCALAR_W-1:0];
  assign vRd        = rc_q;
  assign modeSelOut = mode_q;

`ifdef WB_FORWARD_EN
  logic              fwd_fire;
  logic              fwd_valid_q;
  logic [3:0]        fwd_rd_q;
  logic [DATA_W-1:0] fwd_data_q;

  // A bundle is complete when its last vector beat retires, or when a
  // scalar-only write retires (a scalar riding with a vector waits for the vector).
  assign fwd_fire = en && (((state == VEC) && (beat == LAST_BEAT)) ||
                           ((state == IDLE) && s_pend));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_fire;
      if (fwd_fire) begin
        fwd_rd_q   <= rc_q;
        fwd_data_q <= result_q;
      end
    end
  end

  assign fwdValid = fwd_valid_q;
  assign fwdRd    = fwd_rd_q;
  assign fwdData  = fwd_data_q;
`else
  assign fwdValid = 1'b0;
  assign fwdRd    = '0;
  assign fwdData  = '0;
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage, at the far end of the memory-stage output buffer: consumes the 302-bit MEM/WB bundle, selects the write-back result (ALU result or memory read data), and drives the scalar and vector register-file write ports. Vector results (144 bits) reach a 48-bit vector write port as three sequential beats, so the stage holds the upstream pipeline with `stall` while a vector write drains. A registered forwarding port exposes the committed value to the execute stage.

## Interface
- `DATA_W`, 144: vector result width.
- `BEAT_W`, 48: vector write-port width; `DATA_W` must be an integer multiple (`NBEATS = DATA_W/BEAT_W`, 3 at defaults).
- `SCALAR_W`, 24: scalar register width; the scalar result is `result[SCALAR_W-1:0]`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  pipeline advance; 0 freezes the stage.
- `bufferIn`  in  302  MEM/WB bundle: [143:0] ALU result, [287:144] memory read data, [291:288] Rc, [292] regWrite, [293] memToReg, [297:294] opCode, [299:298] opType, [300] modeSel, [301] regWriteV.
- `stall`  out  1  upstream must hold `bufferIn` while high.
- `sWe`, `sRd[3:0]`, `sData[SCALAR_W-1:0]`  out  scalar write strobe, index, data.
- `vWe`, `vRd[3:0]`, `vBeat[1:0]`, `vData[BEAT_W-1:0]`  out  vector write strobe, index, beat number, beat data.
- `modeSelOut`  out  1  registered `modeSel` of the last captured bundle.
- `fwdValid`, `fwdRd[3:0]`, `fwdData[DATA_W-1:0]`  out  forwarding port (see Configuration).

## Operation
- result = `memToReg ? bufferIn[287:144] : bufferIn[143:0]`, computed at capture.
- Capture: at a rising edge with `en=1` and `stall=0`, the bundle fields and result are registered. opCode/opType are not decoded.
- FSM states: IDLE, VEC.
- IDLE, capture with regWriteV=1 -> VEC, beat=0. Capture with regWriteV=0 -> stay IDLE.
- VEC, `en=1`: beat increments each edge; when beat = NBEATS-1 -> IDLE, or, if a new bundle is captured at that edge, re-enter per that bundle's regWriteV (back-to-back vectors, no bubble).
- `stall` = (state==VEC) && (beat != NBEATS-1); combinational from registered state.
- Beat k carries `result[k*BEAT_W +: BEAT_W]`; beat 0 = least-significant slice.
- Scalar write: `sWe` high for exactly one enabled cycle after a capture with regWrite=1 (concurrent with beat 0 when both flags set). `sRd`=Rc, `sData`=result[SCALAR_W-1:0].
- Captures with regWrite=regWriteV=0 produce no strobes (bubble).
- `en=0`: no capture, no beat advance, `sWe`=`vWe`=0 (strobes are registered-active AND `en`); data/index outputs hold; sequence resumes unchanged when `en` returns.
- `rst` low mid-sequence: remaining beats discarded, state -> IDLE immediately.

## Timing
- Reset values: state IDLE, beat 0, `stall`=0, all strobes 0, all index/data outputs 0, `modeSelOut`=0, `fwdValid`=0.
- Capture at edge N -> scalar write and vector beat 0 presented in cycle N..N+1, sampled by register file at N+1.
- Vector beats at cycles N, N+1, N+2; `stall` high in cycles N and N+1, low in N+2, so the next bundle is captured at edge N+3.
- Scalar-only throughput: one bundle per cycle, latency 1.
- `vRd` constant across all beats of one vector write.

## Configuration
- `WB_FORWARD_EN` defined: `fwdValid` asserts at the edge the final write of a bundle completes (scalar: N+1; vector: after last beat), for one cycle, with `fwdRd`=Rc and `fwdData`=full result.
- Undefined: forwarding logic omitted; `fwdValid`, `fwdRd`, `fwdData` tied 0; ports retained.

## Test plan
- Reset: drive `rst`=0 mid-vector (after beat 0) -> all outputs 0, state IDLE; after release, first capture behaves normally.
- Scalar pass-through: result=500, Rc=12, regWrite=1, memToReg=0, regWriteV=0 -> one cycle later `sWe`=1, `sRd`=12, `sData`=500, `stall`=0, `vWe`=0.
- memToReg select: ALU=5000, read data=255, memToReg=1, regWrite=1, Rc=3 -> `sData`=255.
- Vector drain: result={48'hC, 48'hB, 48'hA}, Rc=7, regWriteV=1, memToReg=0 -> `vData` A,B,C with `vBeat` 0,1,2, `vRd`=7 throughout; `stall` 1,1,0; next bundle held until edge N+3.
- Freeze: `en`=0 for 2 cycles after beat 0 -> `vWe`=0, beat stays 0, `stall` stays 1; resumes with beat 1 on `en`=1.
- Forwarding (`WB_FORWARD_EN` on): scalar result 35 to Rc=4 -> `fwdValid`=1, `fwdRd`=4, `fwdData`=35 for one cycle; macro off -> forwarding outputs remain 0.
